prog_feeder: RTL



---
 rtl/prog_feeder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/prog_feeder.sv
// Instruction feeder for the processor core: loadable program memory, one-at-a-time
// issue with mvi immediate follow-up, Done handshake, halt detection and Done timeout.
module prog_feeder #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [15:0]       i_load_data,
  input  logic              i_done,
  output logic [15:0]       o_din,
  output logic              o_run,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_retired,
  output logic              o_halted,
  output logic              o_error
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              r_halted;
  logic              w_halted_next;
  logic              r_error;
  logic              w_error_next;

  logic [15:0]       r_mem [0:(2**ADDR_W)-1];
  logic [ADDR_W-1:0] w_pc_p1;
  logic [ADDR_W-1:0] w_pc_p2;
  logic [15:0]       w_instr;
  logic [15:0]       w_imm;
  logic [2:0]        w_opcode;
  logic              w_is_mvi;
  logic              w_is_halt;
  logic              w_load_ok;

  // PC wraps naturally, so an mvi at the top address fetches its immediate from 0.
  assign w_pc_p1   = r_pc + ADDR_W'(1);
  assign w_pc_p2   = r_pc + ADDR_W'(2);
  assign w_instr   = r_mem[r_pc];
  assign w_imm     = r_mem[w_pc_p1];
  assign w_opcode  = w_instr[8:6];
  assign w_is_mvi  = (w_opcode == OP_MVI);
  assign w_is_halt = (w_opcode == OP_HALT);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_load_ok = (r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERROR);

  // Writes are blocked while a program is executing so the words in flight stay stable.
  always_ff @(posedge i_clock) begin
    if (i_load_en && w_load_ok) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_cnt    <= '0;
      r_halted <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_cnt    <= w_cnt_next;
      r_halted <= w_halted_next;
      r_error  <= w_error_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_cnt_next    = r_cnt;
    w_halted_next = r_halted;
    w_error_next  = r_error;
    o_run         = 1'b0;
    o_din         = 16'h0000;
    o_retired     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_pc_next    = i_start_addr;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_is_halt) begin
          w_halted_next = 1'b1;
          w_state_next  = S_HALT;
        end else begin
          o_run        = 1'b1;
          o_din        = w_instr;
          w_cnt_next   = '0;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        o_din = w_is_mvi ? w_imm : w_instr;
        // A Done coinciding with reset is dropped entirely, including the Retired pulse.
        if (i_done && !i_reset) begin
          o_retired    = 1'b1;
          w_pc_next    = w_is_mvi ? w_pc_p2 : w_pc_p1;
          w_state_next = S_ISSUE;
        end else if (w_cnt_inc == CNT_W'(TIMEOUT - 1)) begin
          w_error_next = 1'b1;
          w_state_next = S_ERROR;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_HALT, S_ERROR: begin
        if (i_start) begin
          w_halted_next = 1'b0;
          w_error_next  = 1'b0;
          w_pc_next     = i_start_addr;
          w_state_next  = S_ISSUE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_pc     = r_pc;
  assign o_halted = r_halted;
  assign o_error  = r_error;

endmodule
